// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// rtc_pkg -- shared FSM state, register offsets, BCD limits and calendar helpers
// Rev 1.0
// ============================================================================
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  localparam int unsigned NUM_FIELDS = 6;

  localparam logic [2:0] OFS_SEC   = 3'd0;
  localparam logic [2:0] OFS_MIN   = 3'd1;
  localparam logic [2:0] OFS_HOUR  = 3'd2;
  localparam logic [2:0] OFS_DAY   = 3'd3;
  localparam logic [2:0] OFS_MONTH = 3'd4;
  localparam logic [2:0] OFS_YEAR  = 3'd5;

  localparam logic [7:0] SEC_MAX   = 8'h59;
  localparam logic [7:0] MIN_MAX   = 8'h59;
  localparam logic [7:0] HOUR_MAX  = 8'h23;
  localparam logic [7:0] MONTH_MAX = 8'h12;
  localparam logic [7:0] YEAR_MAX  = 8'h99;

  localparam logic [7:0] ZERO_MIN  = 8'h00;
  localparam logic [7:0] DAY_MIN   = 8'h01;
  localparam logic [7:0] MONTH_MIN = 8'h01;

  function automatic logic is_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'h9) && (v[3:0] <= 4'h9);
  endfunction

  // 10*t + o == 2*t + o (mod 4), so divisibility by 4 needs o even and o[1] == t[0].
  function automatic logic bcd_leap(input logic [7:0] yr);
    return (yr[0] == 1'b0) && (yr[1] == yr[4]);
  endfunction

  function automatic logic [7:0] month_len(input logic [7:0] mon, input logic [7:0] yr);
    logic [7:0] len;
    case (mon)
      8'h02:                      len = bcd_leap(yr) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: len = 8'h30;
      default:                    len = 8'h31;
    endcase
    return len;
  endfunction

  // A field at/above its limit or holding a non-BCD pattern wraps and carries.
  function automatic logic bcd_wraps(input logic [7:0] v, input logic [7:0] hi);
    return (v >= hi) || !is_bcd(v);
  endfunction

  function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi);
    logic [7:0] nxt;
    if (bcd_wraps(v, hi)) begin
      nxt = lo;
    end else if (v[3:0] == 4'h9) begin
      nxt = {v[7:4] + 4'h1, 4'h0};
    end else begin
      nxt = v + 8'h01;
    end
    return nxt;
  endfunction

endpackage : rtc_pkg
`default_nettype wire

// File: rtl/rtc_bcd_timekeeper.sv
`default_nettype none
// ============================================================================
// rtc_bcd_timekeeper -- six packed-BCD time/date counters with carry and leap logic
// Rev 1.0
// ============================================================================
module rtc_bcd_timekeeper
  import rtc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       wr_en_i,
  input  logic [2:0] wr_idx_i,
  input  logic [7:0] wr_data_i,
  output logic [7:0] sec_o,
  output logic [7:0] min_o,
  output logic [7:0] hour_o,
  output logic [7:0] day_o,
  output logic [7:0] month_o,
  output logic [7:0] year_o
);

  logic [7:0] sec_q,   sec_d;
  logic [7:0] min_q,   min_d;
  logic [7:0] hour_q,  hour_d;
  logic [7:0] day_q,   day_d;
  logic [7:0] month_q, month_d;
  logic [7:0] year_q,  year_d;
  logic [7:0] day_max;

  assign day_max = month_len(month_q, year_q);

  // A bus write always wins; the responder never presents a tick in a commit cycle.
  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;
    if (wr_en_i) begin
      case (wr_idx_i)
        OFS_SEC:   sec_d   = wr_data_i;
        OFS_MIN:   min_d   = wr_data_i;
        OFS_HOUR:  hour_d  = wr_data_i;
        OFS_DAY:   day_d   = wr_data_i;
        OFS_MONTH: month_d = wr_data_i;
        OFS_YEAR:  year_d  = wr_data_i;
        default:   ;
      endcase
    end else if (tick_i) begin
      sec_d = bcd_next(sec_q, ZERO_MIN, SEC_MAX);
      if (bcd_wraps(sec_q, SEC_MAX)) begin
        min_d = bcd_next(min_q, ZERO_MIN, MIN_MAX);
        if (bcd_wraps(min_q, MIN_MAX)) begin
          hour_d = bcd_next(hour_q, ZERO_MIN, HOUR_MAX);
          if (bcd_wraps(hour_q, HOUR_MAX)) begin
            day_d = bcd_next(day_q, DAY_MIN, day_max);
            if (bcd_wraps(day_q, day_max)) begin
              month_d = bcd_next(month_q, MONTH_MIN, MONTH_MAX);
              if (bcd_wraps(month_q, MONTH_MAX)) begin
                year_d = bcd_next(year_q, ZERO_MIN, YEAR_MAX);
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sec_q   <= 8'h00;
      min_q   <= 8'h00;
      hour_q  <= 8'h00;
      day_q   <= 8'h01;
      month_q <= 8'h01;
      year_q  <= 8'h00;
    end else begin
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
    end
  end

  assign sec_o   = sec_q;
  assign min_o   = min_q;
  assign hour_o  = hour_q;
  assign day_o   = day_q;
  assign month_o = month_q;
  assign year_o  = year_q;

endmodule : rtc_bcd_timekeeper
`default_nettype wire

// File: rtl/rtc_bus_responder.sv
`default_nettype none
// ============================================================================
// rtc_bus_responder -- RTC chip model on the multiplexed CS/AD/RD/WR byte bus
// Rev 1.0
// ============================================================================
module rtc_bus_responder
  import rtc_pkg::*;
#(
  parameter logic [7:0] CTRL_ADDR = 8'h02,
  parameter logic [7:0] TIME_BASE = 8'h21
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       CS,
  input  logic       AD,
  input  logic       RD,
  input  logic       WR,
  input  logic [7:0] Dato_in,
  output logic [7:0] Dato_out,
  output logic       Dato_oe,
  input  logic       Tick,
  output logic [7:0] Addr_q
);

  logic       cs_q, ad_q, rd_q, wr_q;
  logic [7:0] din_q;

  state_e     state_q, state_d;
  logic [7:0] wdata_q;
  logic [7:0] ctrl_q;
  logic       tick_pend_q, tick_pend_d;

  logic       addr_ld, wdata_ld, commit, rd_snap, oe_clr;
  logic [7:0] ofs;
  logic       in_time, is_ctrl;
  logic       tick_any, tk_tick;
  logic [7:0] rd_data;
  logic [7:0] sec, min, hour, day, month, year;

  // Strobes idle high so the reset edge never looks like a bus cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cs_q  <= 1'b1;
      ad_q  <= 1'b1;
      rd_q  <= 1'b1;
      wr_q  <= 1'b1;
      din_q <= 8'h00;
    end else begin
      cs_q  <= CS;
      ad_q  <= AD;
      rd_q  <= RD;
      wr_q  <= WR;
      din_q <= Dato_in;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cs_q) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!ad_q)      state_d = ST_ADDR;
          else if (!wr_q) state_d = ST_WRITE;
          else if (!rd_q) state_d = ST_READ;
        end
        ST_ADDR:  if (ad_q) state_d = ST_IDLE;
        ST_WRITE: if (wr_q) state_d = ST_IDLE;
        ST_READ:  if (rd_q) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_ld  = !cs_q && !ad_q && ((state_q == ST_IDLE) || (state_q == ST_ADDR));
    wdata_ld = !cs_q && !wr_q &&
               (((state_q == ST_IDLE) && ad_q) || (state_q == ST_WRITE));
    commit   = !cs_q && (state_q == ST_WRITE) && wr_q;
    rd_snap  = !cs_q && (state_q == ST_IDLE) && ad_q && wr_q && !rd_q;
    oe_clr   = cs_q || ((state_q == ST_READ) && rd_q);
  end

  assign ofs     = Addr_q - TIME_BASE;
  assign in_time = (Addr_q >= TIME_BASE) && (ofs < 8'(NUM_FIELDS));
  assign is_ctrl = (Addr_q == CTRL_ADDR);

  always_comb begin
    rd_data = 8'h00;
    if (is_ctrl) begin
      rd_data = ctrl_q;
    end else if (in_time) begin
      case (ofs[2:0])
        OFS_SEC:   rd_data = sec;
        OFS_MIN:   rd_data = min;
        OFS_HOUR:  rd_data = hour;
        OFS_DAY:   rd_data = day;
        OFS_MONTH: rd_data = month;
        OFS_YEAR:  rd_data = year;
        default:   rd_data = 8'h00;
      endcase
    end
  end

  // A tick that collides with a commit is parked one cycle; halt drops ticks outright.
  always_comb begin
    tick_any    = (Tick || tick_pend_q) && !ctrl_q[0];
    tk_tick     = tick_any && !commit;
    tick_pend_d = tick_any && (commit || (Tick && tick_pend_q));
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      ctrl_q      <= 8'h00;
      Dato_out    <= 8'h00;
      Dato_oe     <= 1'b0;
      tick_pend_q <= 1'b0;
    end else begin
      tick_pend_q <= tick_pend_d;
      if (addr_ld) begin
        Addr_q <= din_q;
      end
      if (wdata_ld) begin
        wdata_q <= din_q;
      end
      if (commit && is_ctrl) begin
        ctrl_q <= wdata_q;
      end
      if (rd_snap) begin
        Dato_out <= rd_data;
        Dato_oe  <= 1'b1;
      end else if (oe_clr) begin
        Dato_oe <= 1'b0;
      end
    end
  end

  rtc_bcd_timekeeper u_timekeeper (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .tick_i    (tk_tick),
    .wr_en_i   (commit && in_time && !is_ctrl),
    .wr_idx_i  (ofs[2:0]),
    .wr_data_i (wdata_q),
    .sec_o     (sec),
    .min_o     (min),
    .hour_o    (hour),
    .day_o     (day),
    .month_o   (month),
    .year_o    (year)
  );

endmodule : rtc_bus_responder
`default_nettype wire

// File: tb/tb_rtc_bus_responder.sv
`default_nettype none
// ============================================================================
// tb_rtc_bus_responder -- directed bus transactions against a calendar-level model
// Rev 1.0
// ============================================================================
module tb_rtc_bus_responder;

  localparam logic [7:0] CTRL = 8'h02;
  localparam logic [7:0] TB   = 8'h21;

  logic       Clock = 1'b0;
  logic       Reset, CS, AD, RD, WR, Tick;
  logic [7:0] Dato_in;
  logic [7:0] Dato_out;
  logic       Dato_oe;
  logic [7:0] Addr_q;

  int errs   = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [7:0] exp_out, exp_addr;
  logic       exp_oe;

  // Model state: raw field bytes (sec..year) and control byte.
  logic [7:0] f_m [6];
  logic [7:0] ctrl_m;

  rtc_bus_responder #(.CTRL_ADDR(CTRL), .TIME_BASE(TB)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .CS       (CS),
    .AD       (AD),
    .RD       (RD),
    .WR       (WR),
    .Dato_in  (Dato_in),
    .Dato_out (Dato_out),
    .Dato_oe  (Dato_oe),
    .Tick     (Tick),
    .Addr_q   (Addr_q)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Compare outputs mid-cycle, then step one edge; stimulus changes 1 ns after it.
  task automatic cyc();
    @(negedge Clock);
    if (chk_en) begin
      chk("oe",   {7'b0, Dato_oe}, {7'b0, exp_oe});
      chk("dout", Dato_out, exp_out);
      chk("addr", Addr_q, exp_addr);
    end
    @(posedge Clock);
    #1;
  endtask

  function automatic int bcd2int(input logic [7:0] b);
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic int mdays(input int m, input int y);
    case (m)
      2:             return (y >= 0 && (y % 4) == 0) ? 29 : 28;
      4, 6, 9, 11:   return 30;
      default:       return 31;
    endcase
  endfunction

  task automatic model_reset();
    f_m = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
    ctrl_m = 8'h00;
  endtask

  task automatic model_tick();
    int lo [6];
    int hi [6];
    int v;
    bit carry;
    if (ctrl_m[0]) return;
    lo = '{0, 0, 0, 1, 1, 0};
    hi = '{59, 59, 23, mdays(bcd2int(f_m[4]), bcd2int(f_m[5])), 12, 99};
    carry = 1'b1;
    for (int i = 0; i < 6 && carry; i++) begin
      v = bcd2int(f_m[i]);
      if (v < 0 || v >= hi[i]) begin
        f_m[i] = int2bcd(lo[i]);
      end else begin
        f_m[i] = int2bcd(v + 1);
        carry = 1'b0;
      end
    end
  endtask

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    int idx;
    idx = int'(a) - int'(TB);
    if (a == CTRL) ctrl_m = d;
    else if (idx >= 0 && idx < 6) f_m[idx] = d;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    int idx;
    idx = int'(a) - int'(TB);
    if (a == CTRL) return ctrl_m;
    if (idx >= 0 && idx < 6) return f_m[idx];
    return 8'h00;
  endfunction

  task automatic addr_phase(input logic [7:0] a);
    CS = 1'b0; AD = 1'b0; Dato_in = a;
    cyc(); cyc();
    exp_addr = a;
    cyc();
    AD = 1'b1;
    cyc(); cyc(); cyc();
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d, input bit tick_at_commit);
    addr_phase(a);
    WR = 1'b0; Dato_in = d;
    cyc(); cyc(); cyc();
    WR = 1'b1;
    cyc();
    if (tick_at_commit) Tick = 1'b1;
    cyc();
    Tick = 1'b0;
    model_write(a, d);
    if (tick_at_commit) model_tick();
    cyc(); cyc();
    CS = 1'b1;
    cyc();
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] got);
    addr_phase(a);
    RD = 1'b0;
    cyc(); cyc();
    exp_oe  = 1'b1;
    exp_out = model_read(a);
    cyc(); cyc();
    got = Dato_out;
    RD = 1'b1;
    cyc(); cyc();
    exp_oe = 1'b0;
    cyc();
    CS = 1'b1;
    cyc();
  endtask

  task automatic pulse_tick();
    Tick = 1'b1;
    cyc();
    Tick = 1'b0;
    model_tick();
    cyc(); cyc();
  endtask

  task automatic expect_read(input string name, input logic [7:0] a, input logic [7:0] lit);
    logic [7:0] got;
    read_reg(a, got);
    chk(name, got, lit);
  endtask

  initial begin
    Reset = 1'b1; CS = 1'b1; AD = 1'b1; RD = 1'b1; WR = 1'b1; Tick = 1'b0; Dato_in = 8'h00;
    cyc(); cyc();
    model_reset();
    exp_out = 8'h00; exp_addr = 8'h00; exp_oe = 1'b0;
    chk_en = 1'b1;
    Reset = 1'b0;
    cyc();
    chk("rst_oe",   {7'b0, Dato_oe}, 8'h00);
    chk("rst_dout", Dato_out, 8'h00);
    chk("rst_addr", Addr_q, 8'h00);

    // Plain read after reset
    expect_read("t1_sec", TB, 8'h00);

    // Seconds/minutes/hours all roll into the day
    write_reg(TB + 8'd0, 8'h59, 1'b0);
    write_reg(TB + 8'd1, 8'h59, 1'b0);
    write_reg(TB + 8'd2, 8'h23, 1'b0);
    pulse_tick();
    expect_read("t2_sec",  TB + 8'd0, 8'h00);
    expect_read("t2_min",  TB + 8'd1, 8'h00);
    expect_read("t2_hour", TB + 8'd2, 8'h00);
    expect_read("t2_day",  TB + 8'd3, 8'h02);

    // Non-BCD values are stored verbatim and wrap with carry
    write_reg(TB, 8'h5A, 1'b0);
    expect_read("nb_store", TB, 8'h5A);
    pulse_tick();
    expect_read("nb_sec", TB, 8'h00);
    expect_read("nb_min", TB + 8'd1, 8'h01);

    // February in a non-leap and a leap year
    write_reg(TB + 8'd0, 8'h59, 1'b0);
    write_reg(TB + 8'd1, 8'h59, 1'b0);
    write_reg(TB + 8'd2, 8'h23, 1'b0);
    write_reg(TB + 8'd3, 8'h28, 1'b0);
    write_reg(TB + 8'd4, 8'h02, 1'b0);
    write_reg(TB + 8'd5, 8'h03, 1'b0);
    pulse_tick();
    expect_read("t3_day",  TB + 8'd3, 8'h01);
    expect_read("t3_mon",  TB + 8'd4, 8'h03);
    expect_read("t3_hour", TB + 8'd2, 8'h00);
    write_reg(TB + 8'd0, 8'h59, 1'b0);
    write_reg(TB + 8'd1, 8'h59, 1'b0);
    write_reg(TB + 8'd2, 8'h23, 1'b0);
    write_reg(TB + 8'd3, 8'h28, 1'b0);
    write_reg(TB + 8'd4, 8'h02, 1'b0);
    write_reg(TB + 8'd5, 8'h04, 1'b0);
    pulse_tick();
    expect_read("t3_leap_day", TB + 8'd3, 8'h29);
    expect_read("t3_leap_mon", TB + 8'd4, 8'h02);

    // Halt drops ticks; clearing it resumes counting
    write_reg(CTRL, 8'h01, 1'b0);
    for (int i = 0; i < 5; i++) pulse_tick();
    expect_read("t4_halt_sec", TB, 8'h00);
    expect_read("t4_ctrl", CTRL, 8'h01);
    write_reg(CTRL, 8'h00, 1'b0);
    pulse_tick();
    expect_read("t4_run_sec", TB, 8'h01);

    // Tick coincident with a commit is deferred, not lost
    write_reg(TB, 8'h10, 1'b1);
    expect_read("t5_sec", TB, 8'h11);

    // CS abort mid-write leaves the target untouched
    addr_phase(TB);
    WR = 1'b0; Dato_in = 8'h45;
    cyc(); cyc(); cyc();
    CS = 1'b1;
    cyc(); cyc();
    WR = 1'b1;
    cyc(); cyc();
    expect_read("t6_abort_sec", TB, 8'h11);
    expect_read("t6_unmapped", 8'h7F, 8'h00);

    // Reset while a read is being driven
    addr_phase(TB + 8'd3);
    RD = 1'b0;
    cyc(); cyc();
    exp_oe  = 1'b1;
    exp_out = model_read(TB + 8'd3);
    cyc();
    Reset = 1'b1; RD = 1'b1; CS = 1'b1;
    cyc();
    model_reset();
    exp_oe = 1'b0; exp_out = 8'h00; exp_addr = 8'h00;
    chk("t6_rst_oe", {7'b0, Dato_oe}, 8'h00);
    Reset = 1'b0;
    cyc();
    expect_read("t6_rst_sec", TB, 8'h00);
    expect_read("t6_rst_day", TB + 8'd3, 8'h01);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule : tb_rtc_bus_responder
`default_nettype wire
